// File: rtl/frequency_analyzer_pkg.sv
// Shared definitions for the frequency analyzer sequencer: FSM encoding and default widths.
package frequency_analyzer_pkg;

  localparam int unsigned DEFAULT_FRAME_COUNT_WIDTH = 8;
  localparam int unsigned DEFAULT_TIMEOUT_WIDTH     = 24;
  localparam logic [DEFAULT_TIMEOUT_WIDTH-1:0] DEFAULT_TIMEOUT_CYCLES = 24'd1000000;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CLEAR      = 3'd1,
    ST_WAIT_FRAME = 3'd2,
    ST_MEASURE    = 3'd3,
    ST_DONE       = 3'd4
  } state_t;

endpackage : frequency_analyzer_pkg

// File: rtl/frequency_analyzer_timeout.sv
// Watchdog counter for the sequencer: counts while enabled, restarts on clear,
// and flags the cycle on which the count would reach the limit.
module frequency_analyzer_timeout
  import frequency_analyzer_pkg::*;
#(
  parameter int unsigned TIMEOUT_WIDTH = DEFAULT_TIMEOUT_WIDTH,
  parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic pixel_clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  logic [TIMEOUT_WIDTH-1:0] count;

  // Cycle counter: clear has priority over counting.
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TIMEOUT_WIDTH'(1);
    end
  end

  // Expiry fires on the edge that would bring the count to TIMEOUT_CYCLES.
  assign expired_c = enable && !clear && (count == (TIMEOUT_CYCLES - TIMEOUT_WIDTH'(1)));

endmodule : frequency_analyzer_timeout

// File: rtl/frequency_analyzer_sequencer.sv
// Frequency analyzer sequencer: arms an external analyzer, measures a number of
// frames, and reports completion/abort. All outputs are registered.
// Optional watchdog enabled by defining FREQUENCY_ANALYZER_SEQUENCER_TIMEOUT_EN.
module frequency_analyzer_sequencer
  import frequency_analyzer_pkg::*;
#(
  parameter int unsigned FRAME_COUNT_WIDTH = DEFAULT_FRAME_COUNT_WIDTH,
  parameter int unsigned TIMEOUT_WIDTH     = DEFAULT_TIMEOUT_WIDTH,
  parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                         pixel_clock,
  input  logic                         reset,
  input  logic                         frame_start,
  input  logic                         arm,
  input  logic                         abort,
  input  logic                         ack,
  input  logic [FRAME_COUNT_WIDTH-1:0] num_frames,
  output logic                         analyzer_clear,
  output logic                         analyzer_start,
  output logic                         analyzer_stop,
  output logic                         busy,
  output logic                         done,
  output logic                         aborted,
  output logic                         timeout,
  output logic                         irq,
  output logic [FRAME_COUNT_WIDTH-1:0] frames_done
);

  state_t                       state;
  state_t                       next_state;
  logic [FRAME_COUNT_WIDTH-1:0] target;
  logic [FRAME_COUNT_WIDTH-1:0] target_d;
  logic [FRAME_COUNT_WIDTH-1:0] frames_done_d;
  logic                         clear_d;
  logic                         start_d;
  logic                         stop_d;
  logic                         busy_d;
  logic                         done_d;
  logic                         aborted_d;
  logic                         timeout_d;
  logic                         irq_d;
  logic                         timeout_hit_c;

`ifdef FREQUENCY_ANALYZER_SEQUENCER_TIMEOUT_EN
  logic timeout_clear_c;
  logic timeout_en_c;

  // Restart the watchdog when leaving CLEAR (the only path into WAIT_FRAME) and on each frame.
  assign timeout_clear_c = (state == ST_CLEAR) || frame_start;
  assign timeout_en_c    = (state == ST_WAIT_FRAME) || (state == ST_MEASURE);

  frequency_analyzer_timeout #(
    .TIMEOUT_WIDTH  (TIMEOUT_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .clear       (timeout_clear_c),
    .enable      (timeout_en_c),
    .expired_c   (timeout_hit_c)
  );
`else
  logic unused_timeout_cfg;

  // No watchdog in this build; the limit is intentionally left unconnected.
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit_c      = 1'b0;
`endif

  // Next-state and next-output logic; abort outranks every other event.
  always_comb begin
    next_state    = state;
    target_d      = target;
    frames_done_d = frames_done;
    aborted_d     = aborted;
    timeout_d     = timeout;
    clear_d       = 1'b0;
    start_d       = 1'b0;
    stop_d        = 1'b0;
    irq_d         = 1'b0;

    case (state)
      ST_IDLE: begin
        if (arm && !abort && (num_frames != '0)) begin
          next_state    = ST_CLEAR;
          clear_d       = 1'b1;
          target_d      = num_frames;
          frames_done_d = '0;
          aborted_d     = 1'b0;
          timeout_d     = 1'b0;
        end
      end
      ST_CLEAR: begin
        if (abort) begin
          next_state = ST_IDLE;
          aborted_d  = 1'b1;
        end else begin
          next_state = ST_WAIT_FRAME;
        end
      end
      ST_WAIT_FRAME: begin
        if (abort) begin
          next_state = ST_IDLE;
          aborted_d  = 1'b1;
        end else if (frame_start) begin
          next_state = ST_MEASURE;
          start_d    = 1'b1;
        end else if (timeout_hit_c) begin
          next_state = ST_IDLE;
          timeout_d  = 1'b1;
          irq_d      = 1'b1;
        end
      end
      ST_MEASURE: begin
        if (abort) begin
          next_state = ST_IDLE;
          aborted_d  = 1'b1;
          stop_d     = 1'b1;
        end else if (frame_start) begin
          frames_done_d = frames_done + FRAME_COUNT_WIDTH'(1);
          if (frames_done_d == target) begin
            next_state = ST_DONE;
            stop_d     = 1'b1;
            irq_d      = 1'b1;
          end
        end else if (timeout_hit_c) begin
          next_state = ST_IDLE;
          timeout_d  = 1'b1;
          stop_d     = 1'b1;
          irq_d      = 1'b1;
        end
      end
      ST_DONE: begin
        if (ack) begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase

    busy_d = (next_state == ST_CLEAR) || (next_state == ST_WAIT_FRAME) ||
             (next_state == ST_MEASURE);
    done_d = (next_state == ST_DONE);
  end

  // State and registered outputs; reset silences every pulse immediately.
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      target         <= '0;
      frames_done    <= '0;
      analyzer_clear <= 1'b0;
      analyzer_start <= 1'b0;
      analyzer_stop  <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      aborted        <= 1'b0;
      timeout        <= 1'b0;
      irq            <= 1'b0;
    end else begin
      state          <= next_state;
      target         <= target_d;
      frames_done    <= frames_done_d;
      analyzer_clear <= clear_d;
      analyzer_start <= start_d;
      analyzer_stop  <= stop_d;
      busy           <= busy_d;
      done           <= done_d;
      aborted        <= aborted_d;
      timeout        <= timeout_d;
      irq            <= irq_d;
    end
  end

endmodule : frequency_analyzer_sequencer

// File: doc/frequency_analyzer_sequencer.md
FREQUENCY_ANALYZER_SEQUENCER -- requirements
Module: frequency_analyzer_sequencer

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
- FRAME_COUNT_WIDTH, 8, width of num_frames and frames_done.
- TIMEOUT_WIDTH, 24, width of the timeout counter.
- TIMEOUT_CYCLES, 24'd1000000, cycles without frame_start before timeout (used only when the configuration macro is defined).

REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning). There is one clock, pixel_clock, and reset is synchronous and active-high.
- pixel_clock, in, 1, sole clock.
- reset, in, 1, synchronous active-high reset.
- frame_start, in, 1, one-cycle pulse on the first pixel of each frame.
- arm, in, 1, one-cycle request to start a measurement.
- abort, in, 1, one-cycle request to cancel a measurement.
- ack, in, 1, software acknowledge of done.
- num_frames, in, FRAME_COUNT_WIDTH, frames to measure; sampled on arm.
- analyzer_clear, out, 1, one-cycle clear pulse to the analyzer.
- analyzer_start, out, 1, one-cycle start pulse to the analyzer.
- analyzer_stop, out, 1, one-cycle stop pulse to the analyzer.
- busy, out, 1, high in any state other than IDLE and DONE.
- done, out, 1, high in DONE.
- aborted, out, 1, sticky flag; cleared by an accepted arm.
- timeout, out, 1, sticky flag; cleared by an accepted arm.
- irq, out, 1, one-cycle completion interrupt.
- frames_done, out, FRAME_COUNT_WIDTH, frames completed in the current or last run.

Function
REQ-003 The FSM states SHALL be IDLE, CLEAR, WAIT_FRAME, MEASURE and DONE, and all outputs SHALL be registered.
REQ-004 In IDLE, arm with num_frames!=0 SHALL latch num_frames, clear frames_done, aborted and timeout, and move to CLEAR; arm with num_frames==0 SHALL be ignored.
REQ-005 CLEAR SHALL assert analyzer_clear for exactly 1 cycle, then move to WAIT_FRAME.
REQ-006 In WAIT_FRAME, frame_start SHALL move to MEASURE and assert analyzer_start in the next cycle (latency 1).
REQ-007 In MEASURE, each frame_start SHALL increment frames_done; when the incremented value equals the latched num_frames, the block SHALL pulse analyzer_stop for 1 cycle and enter DONE.
REQ-008 On entry to DONE, irq SHALL pulse for exactly 1 cycle; done SHALL stay high until ack, and ack SHALL return the FSM to IDLE.
REQ-009 arm SHALL be ignored in every state except IDLE, and ack SHALL be ignored outside DONE.
REQ-010 abort in CLEAR or WAIT_FRAME SHALL return the FSM to IDLE and set aborted, with no stop pulse and no irq.
REQ-011 abort in MEASURE SHALL pulse analyzer_stop, set aborted, return the FSM to IDLE, and raise no irq.
REQ-012 When abort coincides with arm or frame_start, abort SHALL win.
REQ-013 frames_done SHALL never wrap; it terminates at num_frames, whose maximum is 2^FRAME_COUNT_WIDTH-1.
REQ-014 analyzer_clear, analyzer_start and analyzer_stop SHALL be mutually exclusive in any cycle.

Reset
REQ-015 reset SHALL force IDLE and drive every output, including frames_done, aborted and timeout, to 0 on the next pixel_clock edge.
REQ-016 reset during MEASURE SHALL NOT generate analyzer_stop or irq.

Configuration
REQ-017 With FREQUENCY_ANALYZER_SEQUENCER_TIMEOUT_EN defined:
- a counter SHALL clear on entry to WAIT_FRAME and on every frame_start, and count in WAIT_FRAME and MEASURE;
- reaching TIMEOUT_CYCLES SHALL set timeout, pulse analyzer_stop if the FSM is in MEASURE, pulse irq, and go to IDLE;
- abort SHALL take priority over timeout.
REQ-018 Without the macro, no counter SHALL exist, timeout SHALL be constant 0, and TIMEOUT_CYCLES SHALL be unused.

Structure
REQ-019 The shared package frequency_analyzer_pkg SHALL hold the state encoding constants and the default widths.
REQ-020 The timeout counter SHALL be a sub-module, frequency_analyzer_timeout, instantiated only under the macro.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- arm with num_frames=3, then 4 frame_start pulses 100 cycles apart -> clear 1 cycle after arm, start 1 cycle after the 1st frame_start, stop with frames_done=3 on the 4th, a single irq, done held until ack.
- arm with num_frames=0 -> FSM stays in IDLE, all outputs 0.
- abort 2 cycles after the 2nd frame_start with num_frames=5 -> stop pulse, aborted=1, no irq, IDLE.
- reset asserted in MEASURE -> all outputs 0 next cycle, no stop, no irq.
- abort coinciding with frame_start in WAIT_FRAME -> no start pulse, aborted=1.
- With the macro and TIMEOUT_CYCLES=50, arm then no frame_start -> timeout=1 and an irq at cycle 50 after entering WAIT_FRAME.
